// File: rtl/sumador_serial_ctrl.sv
// ---------------------------------------------------------------------------
// sumador_serial_ctrl
// Bit-serial adder. One full-adder cell is reused over N cycles. The
// operands are shifted out LSB first, and each sum bit is shifted into S
// from the MSB side. After N bits, S holds the full sum and done pulses
// for one cycle.
//
// Ports
//   clk    : system clock, rising edge
//   rst    : synchronous, active-high reset
//   start  : begin an addition (only honoured in IDLE)
//   A, B   : N-bit operands, captured on the accepting edge
//   Cin    : carry-in, captured on the accepting edge
//   S      : registered sum, held until the next accept or reset
//   Cout   : registered final carry-out, same hold rule as S
//   busy   : high while bits are being added
//   done   : one-cycle pulse, S/Cout valid
// ---------------------------------------------------------------------------
module sumador_serial_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SUMA, FIN} state_t;

  state_t        r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_c;
  logic [CW-1:0] r_cnt;

  // The single full-adder cell.
  logic w_sum;
  logic w_cout;
  assign w_sum  = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      S       <= '0;
      Cout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_c     <= Cin;
            r_cnt   <= '0;
            S       <= '0;
            Cout    <= 1'b0;
            r_state <= SUMA;
          end
        end
        SUMA: begin
          S   <= {w_sum, S[N-1:1]};
          r_a <= r_a >> 1;
          r_b <= r_b >> 1;
          r_c <= w_cout;
          // The counter is held on the last bit so it never wraps inside
          // an operation. It is cleared again on the next accept.
          if (r_cnt == CW'(N - 1)) begin
            Cout    <= w_cout;
            r_state <= FIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == SUMA);
  assign done = (r_state == FIN);

endmodule

// File: tb/tb_sumador_serial_ctrl.sv
module tb_sumador_serial_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         Cin = 1'b0;
  logic [N-1:0] S;
  logic         Cout;
  logic         busy;
  logic         done;

  sumador_serial_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .S(S), .Cout(Cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Reference model. An operation is described by its accept edge and
  // its full arithmetic sum. Edge-relative timing gives busy/done, and the
  // sum gives S/Cout:
  //   - busy after the accept edge and the next N-1 edges
  //   - done right after N edges
  //   - after j bits, S holds the low j bits of the sum, left-justified
  int   t = 0;
  int   acc_e = 0;
  bit   act = 0;
  int   msum = 0;
  logic [31:0] es = 0;
  logic        ec = 0;

  task automatic tick();
    int j;
    logic eb, ed;
    @(posedge clk);
    t++;
    if (rst) begin
      act = 0; es = 0; ec = 0;
    end else if ((!act || t > acc_e + N + 1) && start) begin
      act = 1; acc_e = t; es = 0; ec = 0;
      msum = int'(A) + int'(B) + int'(Cin);
    end
    eb = 0; ed = 0;
    if (act) begin
      j = t - acc_e;
      if (j < N) begin
        eb = 1;
        es = (j == 0) ? 0 : (((msum & ((1 << j) - 1)) << (N - j)) & ((1 << N) - 1));
      end else if (j == N) begin
        ed = 1;
        es = msum & ((1 << N) - 1);
        ec = msum[N];
      end
    end
    @(negedge clk);
    chk("busy", 32'(busy), 32'(eb));
    chk("done", 32'(done), 32'(ed));
    chk("S", 32'(S), es);
    chk("Cout", 32'(Cout), 32'(ec));
  endtask

  // One start pulse from IDLE. Checks that done arrives N edges after the
  // accepting edge and that the result matches fixed expected values.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input logic [N-1:0] xs, input logic xc, input string tag);
    int lat;
    lat = -1;
    A = a; B = b; Cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    A = ~a; B = ~b; Cin = ~c;
    for (int i = 0; i < N + 4; i++) begin
      tick();
      if (done) begin lat = i + 1; break; end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(N));
    chk({tag, "_S"}, 32'(S), 32'(xs));
    chk({tag, "_Cout"}, 32'(Cout), 32'(xc));
    tick();
  endtask

  initial begin
    int busy_cnt;
    int dn_t[$];
    bit saw_done;

    // Reset.
    rst = 1'b1; start = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();

    // Zero case. Also counts the busy cycles.
    A = 8'h00; B = 8'h00; Cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 1;
    for (int i = 0; i < N + 4 && !done; i++) begin
      tick();
      if (busy) busy_cnt++;
    end
    chk("zero_busy_cycles", 32'(busy_cnt), 32'(N));
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_S", 32'(S), 32'h00);
    tick();

    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ovf1");
    run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "ovf2");
    run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "plain");

    // Busy lockout: a second start while busy is ignored, and operand
    // changes after the accept do not affect the result.
    A = 8'h21; B = 8'h43; Cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; A = 8'h12; B = 8'h34;
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N + 4 && !done; i++) tick();
    chk("lock_done", 32'(done), 32'd1);
    chk("lock_S", 32'(S), 32'h64);
    busy_cnt = 0;
    repeat (N + 2) begin tick(); if (busy) busy_cnt++; end
    chk("lock_no_second", 32'(busy_cnt), 32'd0);

    // Reset on the 4th SUMA edge aborts with no done pulse.
    A = 8'h05; B = 8'h09; Cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_S", 32'(S), 32'd0);
    chk("abort_Cout", 32'(Cout), 32'd0);
    saw_done = 0;
    repeat (N + 2) begin tick(); if (done) saw_done = 1; end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    run_op(8'h01, 8'h01, 1'b1, 8'h03, 1'b0, "post_rst");

    // Back-to-back with start held high.
    A = 8'h80; B = 8'h80; Cin = 1'b0; start = 1'b1;
    repeat (32) begin tick(); if (done) dn_t.push_back(t); end
    start = 1'b0;
    repeat (N + 3) tick();
    chk("b2b_count", 32'(dn_t.size()), 32'd3);
    if (dn_t.size() >= 3) begin
      chk("b2b_gap1", 32'(dn_t[1] - dn_t[0]), 32'(N + 2));
      chk("b2b_gap2", 32'(dn_t[2] - dn_t[1]), 32'(N + 2));
    end

    // Random traffic against the model.
    repeat (400) begin
      A = N'($urandom); B = N'($urandom); Cin = 1'($urandom);
      start = ($urandom % 4) == 0;
      rst = ($urandom % 60) == 0;
      tick();
    end
    rst = 1'b0; start = 1'b0;
    repeat (N + 3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
